// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bundle of the unified memory arbiter.
// The arbiter takes the slave view; core ports and memory take the master view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [3:0]        d_be;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output d_gnt, d_rvalid, d_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output d_req, d_we, d_be, d_addr, d_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory.
// Data wins by default; a saturating starve counter forces a fetch grant.
module mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           halt,
   mem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_D,
      OWN_DW
   } owner_e;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   owner_e            owner_q, owner_d;
   logic [3:0]        starve_q, starve_d;
   logic              active;
   logic              force_if;
   logic              if_gnt;
   logic              d_gnt;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;
   logic [DATA_W-1:0] if_rdata;
   logic [DATA_W-1:0] d_rdata;

   always_comb begin
      active   = rst && !halt;
      force_if = (starve_q == STARVE_LIM) && bus.if_req;
      if_gnt   = 1'b0;
      d_gnt    = 1'b0;
      if (active) begin
         priority case (1'b1)
            force_if:   if_gnt = 1'b1;
            bus.d_req:  d_gnt  = 1'b1;
            bus.if_req: if_gnt = 1'b1;
            default:    ;
         endcase
      end
   end

   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      if (if_gnt) begin
         addr_mux = bus.if_addr;
      end else if (d_gnt) begin
         addr_mux  = bus.d_addr;
         wdata_mux = bus.d_wdata;
      end
   end

   assign bus.if_gnt    = if_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.mem_en    = if_gnt | d_gnt;
   assign bus.mem_we    = d_gnt & bus.d_we;
   assign bus.mem_be    = if_gnt ? 4'hF :
                          d_gnt  ? bus.d_be : 4'h0;
   assign bus.mem_addr  = addr_mux;
   assign bus.mem_wdata = wdata_mux;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q  <= OWN_NONE;
         starve_q <= '0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      owner_d = OWN_NONE;
      if (if_gnt) begin
         owner_d = OWN_IF;
      end else if (d_gnt) begin
         owner_d = bus.d_we ? OWN_DW : OWN_D;
      end
   end

   // Halt holds the counter implicitly: no grant means neither branch fires.
   always_comb begin
      starve_d = starve_q;
      if (if_gnt) begin
         starve_d = '0;
      end else if (bus.if_req && d_gnt && starve_q < STARVE_LIM) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_comb begin
      bus.if_rvalid = 1'b0;
      bus.d_rvalid  = 1'b0;
      if_rdata      = '0;
      d_rdata       = '0;
      unique case (owner_q)
         OWN_IF: begin
            bus.if_rvalid = 1'b1;
            if_rdata      = bus.mem_rdata;
         end
         OWN_D: begin
            bus.d_rvalid = 1'b1;
            d_rdata      = bus.mem_rdata;
         end
         OWN_DW: bus.d_rvalid = 1'b1;
         default: ;
      endcase
   end

   assign bus.if_rdata = if_rdata;
   assign bus.d_rdata  = d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level model
// of the fetch/data arbitration rules.
module tb_mem_arbiter;

   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int SMAX = 4;

   logic clk  = 1'b0;
   logic rst  = 1'b0;
   logic halt = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .STARVE_MAX(SMAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .halt(halt),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic idle();
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_be      = 4'h0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_rdata = '0;
   endtask

   task automatic test_reset();
      logic [5:0]   ctl;
      logic [131:0] dat;
      rst           = 1'b0;
      halt          = 1'b0;
      idle();
      bus.if_req    = 1'b1;
      bus.d_req     = 1'b1;
      bus.d_we      = 1'b1;
      bus.d_be      = 4'hF;
      bus.d_wdata   = 32'hFFFF_FFFF;
      bus.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      #1;
      ctl = {bus.if_gnt, bus.d_gnt, bus.if_rvalid,
             bus.d_rvalid, bus.mem_en, bus.mem_we};
      n_checks++;
      if (ctl !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b, expected 000000", ctl);
      end
      dat = {bus.if_rdata, bus.d_rdata, bus.mem_addr,
             bus.mem_wdata, bus.mem_be};
      n_checks++;
      if (dat !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h, expected 0", dat);
      end
      idle();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_fetch();
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 16'h0010;
      #1;
      n_checks++;
      if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
           bus.mem_be, bus.mem_addr} !== {4'b1010, 4'hF, 16'h0010}) begin
         n_fail++;
         $display("FAIL fetch_grant: got gnt=%b%b en=%b we=%b be=%h a=%h, expected 1 0 1 0 f 0010",
                  bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
                  bus.mem_be, bus.mem_addr);
      end
      @(negedge clk);
      bus.if_req    = 1'b0;
      bus.mem_rdata = 32'h0000_0013;
      #1;
      n_checks++;
      if ({bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.if_gnt}
          !== {1'b1, 32'h0000_0013, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL fetch_resp: got rv=%b rd=%h drv=%b gnt=%b, expected 1 00000013 0 0",
                  bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.if_gnt);
      end
   endtask

   task automatic test_store();
      @(negedge clk);
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 16'h0040;
      bus.d_be    = 4'b0011;
      bus.d_wdata = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr,
           bus.mem_wdata} !== {3'b111, 4'b0011, 16'h0040, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL store_grant: got g=%b en=%b we=%b be=%b a=%h wd=%h, expected 1 1 1 0011 0040 deadbeef",
                  bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be,
                  bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
      idle();
      bus.mem_rdata = 32'h1234_5678;
      #1;
      n_checks++;
      if ({bus.d_rvalid, bus.d_rdata, bus.if_rvalid}
          !== {1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL store_ack: got rv=%b rd=%h ifrv=%b, expected 1 00000000 0",
                  bus.d_rvalid, bus.d_rdata, bus.if_rvalid);
      end
   endtask

   task automatic test_starvation();
      logic [1:0] exp_g;
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 16'h0100;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 16'h0200;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         exp_g = ((i % 5) == 4) ? 2'b10 : 2'b01;
         n_checks++;
         if ({bus.if_gnt, bus.d_gnt} !== exp_g) begin
            n_fail++;
            $display("FAIL starve_pattern[%0d]: got if/d=%b, expected %b",
                     i, {bus.if_gnt, bus.d_gnt}, exp_g);
         end
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.if_req  = (k < 3);
         bus.if_addr = 16'(k);
         exp_d       = 32'hA000_0000 | 32'(k - 1);
         bus.mem_rdata = (k > 0) ? exp_d : 32'h0;
         #1;
         if (k < 3) begin
            n_checks++;
            if ({bus.if_gnt, bus.mem_addr} !== {1'b1, 16'(k)}) begin
               n_fail++;
               $display("FAIL b2b_grant[%0d]: got g=%b a=%h, expected 1 %h",
                        k, bus.if_gnt, bus.mem_addr, 16'(k));
            end
         end
         n_checks++;
         if (k == 0) begin
            if (bus.if_rvalid !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_resp[0]: got rv=%b, expected 0", bus.if_rvalid);
            end
         end else if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, exp_d}) begin
            n_fail++;
            $display("FAIL b2b_resp[%0d]: got rv=%b rd=%h, expected 1 %h",
                     k, bus.if_rvalid, bus.if_rdata, exp_d);
         end
      end
   endtask

   task automatic test_halt();
      @(negedge clk);
      idle();
      bus.d_req  = 1'b1;
      bus.d_addr = 16'h0005;
      #1;
      n_checks++;
      if (bus.d_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_load_gnt: got %b, expected 1", bus.d_gnt);
      end
      @(negedge clk);
      bus.d_req     = 1'b0;
      halt          = 1'b1;
      bus.if_req    = 1'b1;
      bus.if_addr   = 16'h0077;
      bus.mem_rdata = 32'hCAFE_0001;
      #1;
      n_checks++;
      if ({bus.d_rvalid, bus.d_rdata, bus.if_gnt, bus.d_gnt, bus.mem_en}
          !== {1'b1, 32'hCAFE_0001, 3'b000}) begin
         n_fail++;
         $display("FAIL halt_inflight: got rv=%b rd=%h g=%b%b en=%b, expected 1 cafe0001 0 0 0",
                  bus.d_rvalid, bus.d_rdata, bus.if_gnt, bus.d_gnt, bus.mem_en);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid}
          !== 5'b0) begin
         n_fail++;
         $display("FAIL halt_hold: got g=%b%b en=%b rv=%b%b, expected all 0",
                  bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid);
      end
      @(negedge clk);
      halt = 1'b0;
      #1;
      n_checks++;
      if ({bus.if_gnt, bus.mem_addr} !== {1'b1, 16'h0077}) begin
         n_fail++;
         $display("FAIL halt_release: got g=%b a=%h, expected 1 0077",
                  bus.if_gnt, bus.mem_addr);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      idle();
      bus.d_req  = 1'b1;
      bus.d_addr = 16'h0009;
      #1;
      n_checks++;
      if (bus.d_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_gnt: got %b, expected 1", bus.d_gnt);
      end
      @(posedge clk);
      bus.mem_rdata = 32'h5555_AAAA;
      #2;
      n_checks++;
      if (bus.d_rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_pre: got rv=%b, expected 1", bus.d_rvalid);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({bus.d_rvalid, bus.d_rdata, bus.d_gnt, bus.if_gnt, bus.mem_en,
           bus.mem_addr} !== '0) begin
         n_fail++;
         $display("FAIL rmid_async: got rv=%b rd=%h g=%b%b en=%b a=%h, expected all 0",
                  bus.d_rvalid, bus.d_rdata, bus.d_gnt, bus.if_gnt,
                  bus.mem_en, bus.mem_addr);
      end
      @(negedge clk);
      idle();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         n_checks++;
         if ({bus.d_rvalid, bus.if_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_after[%0d]: got rv=%b%b, expected 00",
                     i, bus.d_rvalid, bus.if_rvalid);
         end
      end
   endtask

   task automatic test_random();
      int          m_starve, m_owner, win;
      bit          ip, dp;
      logic [15:0] ia, da;
      logic        dwe;
      logic [3:0]  dbe;
      logic [31:0] dwd, rd;
      logic [1:0]  exp_g, act_g;
      logic [53:0] exp_m, act_m;
      logic [65:0] exp_r, act_r;
      @(negedge clk);
      idle();
      rst = 1'b0;
      @(negedge clk);
      rst      = 1'b1;
      m_starve = 0;
      m_owner  = 0;
      ip       = 1'b0;
      dp       = 1'b0;
      ia = '0; da = '0; dwe = 1'b0; dbe = '0; dwd = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         halt = ($urandom_range(0, 9) == 0);
         if (!ip && $urandom_range(0, 2) != 0) begin
            ip = 1'b1;
            ia = 16'($urandom);
         end
         if (!dp && $urandom_range(0, 7) != 0) begin
            dp  = 1'b1;
            da  = 16'($urandom);
            dwe = 1'($urandom);
            dbe = 4'($urandom);
            dwd = $urandom;
         end
         rd            = $urandom;
         bus.if_req    = ip;
         bus.if_addr   = ia;
         bus.d_req     = dp;
         bus.d_we      = dwe;
         bus.d_be      = dbe;
         bus.d_addr    = da;
         bus.d_wdata   = dwd;
         bus.mem_rdata = rd;
         #1;
         if (halt)                      win = 0;
         else if (ip && m_starve == SMAX) win = 1;
         else if (dp)                   win = 2;
         else if (ip)                   win = 1;
         else                           win = 0;
         exp_g = {win == 1, win == 2};
         if (win == 1)      exp_m = {2'b10, 4'hF, ia, 32'h0};
         else if (win == 2) exp_m = {1'b1, dwe, dbe, da, dwd};
         else               exp_m = '0;
         case (m_owner)
            1:       exp_r = {1'b1, rd, 1'b0, 32'h0};
            2:       exp_r = {1'b0, 32'h0, 1'b1, rd};
            3:       exp_r = {1'b0, 32'h0, 1'b1, 32'h0};
            default: exp_r = '0;
         endcase
         act_g = {bus.if_gnt, bus.d_gnt};
         act_m = {bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr,
                  bus.mem_wdata};
         act_r = {bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata};
         n_checks++;
         if (act_g !== exp_g) begin
            n_fail++;
            $display("FAIL rnd_grant[%0d]: got %b, expected %b", c, act_g, exp_g);
         end
         n_checks++;
         if (act_m !== exp_m) begin
            n_fail++;
            $display("FAIL rnd_mem[%0d]: got %h, expected %h", c, act_m, exp_m);
         end
         n_checks++;
         if (act_r !== exp_r) begin
            n_fail++;
            $display("FAIL rnd_resp[%0d]: got %h, expected %h", c, act_r, exp_r);
         end
         if (win == 1) begin
            m_starve = 0;
            ip       = 1'b0;
            m_owner  = 1;
         end else if (win == 2) begin
            if (ip && m_starve < SMAX) m_starve++;
            dp      = 1'b0;
            m_owner = dwe ? 3 : 2;
         end else begin
            m_owner = 0;
         end
      end
      @(negedge clk);
      idle();
      halt = 1'b0;
   endtask

   initial begin
      idle();
      test_reset();
      test_fetch();
      test_store();
      test_starvation();
      test_back_to_back();
      test_halt();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single-ported unified memory between the instruction-fetch port and the load/store (data) port.
- Arbitrates one access per cycle. Data has fixed priority over fetch, with a starvation guard that forces a fetch grant.
- Routes the one-cycle-latency read response back to the requester that owns it.
- Sits between the core pipeline and the memory array that the riscv-tests hex images are loaded into.

Parameters:
- ADDR_W, 16, word-address width of the memory (0x0000..0xFFFF words).
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive cycles a pending fetch may lose to data before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- halt  in  1  when 1, no new grants; in-flight response still completes.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch word address; stable while if_req is high.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch data valid (one cycle after if_gnt).
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte enables for stores.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data accepted this cycle (combinational).
- d_rvalid  out  1  load data valid, or store acknowledge (one cycle after d_gnt).
- d_rdata  out  DATA_W  load data; 0 on store acknowledge.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we = 0.

Behaviour:
- Reset (rst = 0, asynchronous): resp_owner = NONE, starve_cnt = 0.
  - All outputs 0: gnt, rvalid and rdata outputs, and every mem_* output.
- Grant decision (combinational each cycle; no grants while rst = 0 or halt = 1):
  - force_if = (starve_cnt == STARVE_MAX) && if_req.
  - If force_if: if_gnt = 1.
  - Else if d_req: d_gnt = 1.
  - Else if if_req: if_gnt = 1.
  - At most one gnt is high per cycle.
- Memory drive: the winner's address, we, be and wdata drive mem_*, and mem_en = 1.
  - Fetch grants drive mem_we = 0 and mem_be = 4'hF.
  - With no grant, mem_en = 0 and the remaining mem_* outputs are 0.
- Response FSM, resp_owner in {NONE, IF, D, DW}:
  - Next state is IF on if_gnt, D on a load grant, DW on a store grant, NONE otherwise.
  - In IF: if_rvalid = 1, if_rdata = mem_rdata.
  - In D: d_rvalid = 1, d_rdata = mem_rdata.
  - In DW: d_rvalid = 1, d_rdata = 0.
  - In every other case the rdata outputs are 0.
- Throughput: fully pipelined, one grant per cycle.
  - A new grant in the same cycle as the previous response is legal.
  - Latency from gnt to rvalid is exactly 1 cycle.
- Starvation counter:
  - Increments when if_req = 1 and d_gnt = 1.
  - Clears to 0 on if_gnt.
  - Holds when if_req = 0 or halt = 1.
  - Saturates at STARVE_MAX, never wraps.
- Simultaneous requests on the forced cycle: data loses, keeps d_req high, and is granted the next cycle if still requesting.
- Halt asserted with a response in flight: the response is still delivered the next cycle. Requests stay pending and starve_cnt is frozen.
- Reset mid-operation: an in-flight response is discarded. No rvalid appears in the first cycle after rst deasserts.
- The arbiter does not check or alter request-signal protocol; requesters must hold requests until granted.

Test Plan:
- Reset, then if_req only, if_addr = 0x0010, mem returns 0x00000013 -> if_gnt in the same cycle; next cycle if_rvalid = 1, if_rdata = 0x00000013; d_rvalid stays 0.
- d_req store with d_addr = 0x0040, d_be = 4'b0011, d_wdata = 0xDEADBEEF -> mem_we = 1, mem_be = 4'b0011, mem_wdata = 0xDEADBEEF; next cycle d_rvalid = 1, d_rdata = 0.
- if_req and d_req (loads) both held continuously with STARVE_MAX = 4 -> grant pattern D, D, D, D, IF, D, D, D, D, IF; starve_cnt peaks at 4 and then clears.
- Back-to-back fetches at 0x0000, 0x0001, 0x0002 -> a grant every cycle; if_rvalid high for 3 consecutive cycles carrying data in order.
- Load granted at cycle N with halt = 1 at N+1 and a pending if_req -> d_rvalid at N+1, no grants while halt = 1, if_gnt in the first cycle after halt drops.
- Load granted, then rst = 0 pulsed asynchronously mid-cycle before the response -> all outputs 0 immediately; no d_rvalid after release.
